updown_sweep_controller: RTL

- Sequences a programmable up/down count between a low and a high bound for a requested number of sweeps. Holds at each endpoint for a fixed dwell.
- Exposes the live count and direction for downstream logic, with start/abort control and busy/done/err status.
- Sits above the team's up/down counter datapath, which is extended with enable and load.
- Acts as the control FSM that decides when the counter counts, reverses, holds or reloads.

---
 rtl/updown_sweep_controller_pkg.sv | 33 +++
 rtl/updown_sweep_controller_count_core.sv | 31 +++
 rtl/updown_sweep_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/updown_sweep_controller_pkg.sv
// Shared encodings and constants for the up/down sweep controller and its counter core.
package updown_sweep_controller_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UP      = 3'd1;
  localparam logic [2:0] ST_HOLD_HI = 3'd2;
  localparam logic [2:0] ST_DOWN    = 3'd3;
  localparam logic [2:0] ST_HOLD_LO = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_UP      = ST_UP,
    S_HOLD_HI = ST_HOLD_HI,
    S_DOWN    = ST_DOWN,
    S_HOLD_LO = ST_HOLD_LO
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 15;
  localparam int DWELL_W   = 4;

  // Out-of-range dwell requests are pinned to the nearest legal value so the
  // dwell counter can never be loaded with a value it cannot count down from.
  function automatic int dwell_legal(input int d);
    if (d < DWELL_MIN) return DWELL_MIN;
    if (d > DWELL_MAX) return DWELL_MAX;
    return d;
  endfunction

endpackage

// File: rtl/updown_sweep_controller_count_core.sv
// Up/down counter datapath with synchronous load and count enable.
module updown_count_core
  import updown_sweep_controller_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             up_down_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i) begin
      if (up_down_i == DIR_UP) count_q <= count_q + WIDTH'(1);
      else                     count_q <= count_q - WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/updown_sweep_controller.sv
// Control FSM that sweeps a counter between latched bounds with endpoint dwell.
module updown_sweep_controller
  import updown_sweep_controller_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SWEEPS_W = 4,
  parameter int DWELL    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    lo,
  input  logic [WIDTH-1:0]    hi,
  input  logic [SWEEPS_W-1:0] sweeps,
  output logic [WIDTH-1:0]    count,
  output logic                up_down,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SWEEPS_W-1:0] sweep_cnt
);

  localparam int                  DWELL_C  = dwell_legal(DWELL);
  localparam logic [DWELL_W-1:0]  DWELL_M1 = DWELL_W'(DWELL_C - 1);
  localparam logic [DWELL_W-1:0]  DW_ONE   = DWELL_W'(1);
  localparam logic [SWEEPS_W-1:0] SW_ONE   = SWEEPS_W'(1);

  state_e              state_q;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    hi_q;
  logic [SWEEPS_W-1:0] sweeps_q;
  logic [SWEEPS_W-1:0] sweep_cnt_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic                up_down_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                load_d;
  logic                en_d;
  logic                dir_d;
  logic [WIDTH-1:0]    load_val_d;
  logic                start_req;
  logic                start_ok;
  logic                abort_act;
  logic [SWEEPS_W-1:0] sweep_inc;
  logic [WIDTH-1:0]    count_w;

  // Abort only matters once a sequence is running; in IDLE it also masks start.
  assign start_req = start && !abort;
  assign start_ok  = start_req && (lo < hi) && (sweeps != '0);
  assign abort_act = abort && (state_q != S_IDLE);
  assign sweep_inc = sweep_cnt_q + SW_ONE;

  always_comb begin
    load_d     = 1'b0;
    en_d       = 1'b0;
    dir_d      = up_down_q;
    load_val_d = lo_q;
    if (abort_act) begin
      load_d     = 1'b1;
      load_val_d = lo_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            load_d     = 1'b1;
            load_val_d = lo;
          end
        end
        S_UP: begin
          if (count_w != hi_q) begin
            en_d  = 1'b1;
            dir_d = DIR_UP;
          end
        end
        S_DOWN: begin
          if (count_w != lo_q) begin
            en_d  = 1'b1;
            dir_d = DIR_DOWN;
          end
        end
        default: ;
      endcase
    end
  end

  updown_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en_d),
    .load_i     (load_d),
    .up_down_i  (dir_d),
    .load_val_i (load_val_d),
    .count_o    (count_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      dwell_q     <= '0;
      up_down_q   <= DIR_UP;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort_act) begin
        state_q   <= S_IDLE;
        up_down_q <= DIR_UP;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_ok) begin
              lo_q        <= lo;
              hi_q        <= hi;
              sweeps_q    <= sweeps;
              sweep_cnt_q <= '0;
              up_down_q   <= DIR_UP;
              busy_q      <= 1'b1;
              state_q     <= S_UP;
            end else if (start_req) begin
              err_q <= 1'b1;
            end
          end
          S_UP: begin
            if (count_w == hi_q) begin
              up_down_q <= DIR_DOWN;
              dwell_q   <= DWELL_M1;
              state_q   <= S_HOLD_HI;
            end
          end
          S_HOLD_HI: begin
            if (dwell_q == '0) state_q <= S_DOWN;
            else               dwell_q <= dwell_q - DW_ONE;
          end
          S_DOWN: begin
            // Arrival at lo closes one full lo->hi->lo sweep.
            if (count_w == lo_q) begin
              sweep_cnt_q <= sweep_inc;
              up_down_q   <= DIR_UP;
              if (sweep_inc == sweeps_q) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                dwell_q <= DWELL_M1;
                state_q <= S_HOLD_LO;
              end
            end
          end
          S_HOLD_LO: begin
            if (dwell_q == '0) state_q <= S_UP;
            else               dwell_q <= dwell_q - DW_ONE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign count     = count_w;
  assign up_down   = up_down_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule
